// File: rtl/spi_frame_slave_if.sv
// SPI pin bundle between the Raspberry Pi master and the frame slave.
//   SCK  : SPI clock, mode 0, asynchronous to the slave clk
//   MOSI : master-to-slave data, MSB first
//   MISO : slave-to-master data, MSB first
//   SSEL : frame select, active low
interface spi_frame_slave_if;
    logic SCK;
    logic MOSI;
    logic MISO;
    logic SSEL;

    modport master (output SCK, output MOSI, output SSEL, input MISO);
    modport slave  (input SCK, input MOSI, input SSEL, output MISO);
endinterface

// File: rtl/spi_frame_slave.sv
// SPI slave register frame for the stepper/IO CPLD.
// One fixed-layout frame carries CH stepgen velocities, digital outputs, stepgen
// control, PWM and a trailing checksum. MOSI bytes land in shadow registers and
// are copied to the live outputs only when the checksum of the whole frame is
// zero. MISO returns positions, inputs, rpm and status snapshotted at frame start.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   spi            SPI pins (SCK, MOSI, MISO, SSEL)
//   pos_in/din/rpm values returned to the master
//   vel_out, dout, spolarity, dirtime, steptime, tap, pwm   live outputs
//   commit         one-cycle pulse when a valid frame is applied
//   wdt_kick       pulse coincident with commit when the frame set wdt_en
//   err_cnt        saturating count of rejected frames
module spi_frame_slave #(
    parameter int unsigned CH = 4,
    parameter int unsigned VW = 12,
    parameter int unsigned PW = 21,
    parameter int unsigned OW = 9,
    parameter int unsigned IW = 13,
    parameter int unsigned T  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_frame_slave_if.slave     spi,
    input  logic [CH*PW-1:0]     pos_in,
    input  logic [IW-1:0]        din,
    input  logic [15:0]          rpm,
    output logic [CH*VW-1:0]     vel_out,
    output logic [OW-1:0]        dout,
    output logic                 spolarity,
    output logic [T-1:0]         dirtime,
    output logic [T-1:0]         steptime,
    output logic [1:0]           tap,
    output logic [7:0]           pwm,
    output logic                 commit,
    output logic                 wdt_kick,
    output logic [6:0]           err_cnt
);
    localparam int unsigned N   = 4 * CH + 8;   // index of the checksum byte
    localparam int unsigned BCW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_DONE} state_t;
    state_t state, state_nx;

    logic [2:0]          sck_q, ssel_q, mosi_q;
    logic                sck_rise_c, sck_fall_c, ssel_rise_c, ssel_fall_c, mosi_b;
    logic                start_c, abort_c, byte_done_c, accept_c, reject_c;
    logic [2:0]          bitcnt;
    logic [BCW-1:0]      bytecnt, rx_idx;
    logic [6:0]          rx_sh;
    logic [7:0]          rx_byte_c, rx_byte, rx_sum;
    logic                rx_vld, load_pend;
    logic [7:0]          tx_sh, tx_sum, tx_byte_c;
    logic [CH*PW-1:0]    pos_snap;
    logic [CH*32-1:0]    pos_ext;
    logic [IW-1:0]       din_snap;
    logic [15:0]         rpm_snap;
    logic [7:0]          status_snap;
    logic                last_ok;
    logic [CH*VW-1:0]    vel_sh;
    logic [OW-1:0]       dout_sh;
    logic                spol_sh, wdt_en_sh;
    logic [T-1:0]        dirtime_sh, steptime_sh;
    logic [1:0]          tap_sh;
    logic [7:0]          pwm_sh;

    // Synchronisers; SSEL resets low so a select still held low after reset
    // produces no falling edge until the master deselects first.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q  <= 3'b000;
            ssel_q <= 3'b000;
            mosi_q <= 3'b000;
        end else begin
            sck_q  <= {sck_q[1:0], spi.SCK};
            ssel_q <= {ssel_q[1:0], spi.SSEL};
            mosi_q <= {mosi_q[1:0], spi.MOSI};
        end
    end

    assign sck_rise_c  = sck_q[1] & ~sck_q[2];
    assign sck_fall_c  = ~sck_q[1] & sck_q[2];
    assign ssel_rise_c = ssel_q[1] & ~ssel_q[2];
    assign ssel_fall_c = ~ssel_q[1] & ssel_q[2];
    assign mosi_b      = mosi_q[2];
    assign rx_byte_c   = {rx_sh, mosi_b};

    assign start_c     = ssel_fall_c && (state != S_CHECK);
    assign abort_c     = (state == S_SHIFT) && (ssel_fall_c || ssel_rise_c) && (bytecnt != '0);
    assign byte_done_c = (state == S_SHIFT) && !ssel_fall_c && !ssel_rise_c && sck_rise_c && (bitcnt == 3'd7);
    assign accept_c    = (state == S_CHECK) && (rx_sum == 8'h00);
    assign reject_c    = ((state == S_CHECK) && (rx_sum != 8'h00)) || abort_c;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (ssel_fall_c) state_nx = S_SHIFT;
            S_SHIFT: begin
                if (ssel_fall_c)                                  state_nx = S_SHIFT;
                else if (ssel_rise_c)                             state_nx = S_IDLE;
                else if (byte_done_c && bytecnt == BCW'(N))       state_nx = S_CHECK;
            end
            S_CHECK: state_nx = S_DONE;
            S_DONE: begin
                if (ssel_fall_c)      state_nx = S_SHIFT;
                else if (ssel_rise_c) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Snapshot positions zero-extended to 32 bits per channel
    always_comb begin
        pos_ext = '0;
        for (int c = 0; c < CH; c++) pos_ext[c*32 +: 32] = 32'(pos_snap[c*PW +: PW]);
    end

    // Next MISO byte, selected by the index of the byte about to be sent
    always_comb begin
        tx_byte_c = 8'h00;
        for (int i = 0; i < 4 * CH; i++)
            if (bytecnt == BCW'(i)) tx_byte_c = pos_ext[i*8 +: 8];
        if (bytecnt == BCW'(4*CH))     tx_byte_c = din_snap[7:0];
        if (bytecnt == BCW'(4*CH + 1)) tx_byte_c = 8'(din_snap[IW-1:8]);
        if (bytecnt == BCW'(4*CH + 2)) tx_byte_c = rpm_snap[7:0];
        if (bytecnt == BCW'(4*CH + 3)) tx_byte_c = rpm_snap[15:8];
        if (bytecnt == BCW'(4*CH + 4)) tx_byte_c = status_snap;
        if (bytecnt == BCW'(4*CH + 5)) tx_byte_c = 8'hA5;
        if (bytecnt == BCW'(4*CH + 6)) tx_byte_c = 8'(CH);
        if (bytecnt == BCW'(N))        tx_byte_c = 8'h00 - tx_sum;
    end

    // Bit/byte counting, receive and transmit shifting, frame-start snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt      <= 3'd0;
            bytecnt     <= '0;
            rx_sh       <= 7'd0;
            rx_byte     <= 8'h00;
            rx_idx      <= '0;
            rx_vld      <= 1'b0;
            rx_sum      <= 8'h00;
            tx_sh       <= 8'h00;
            tx_sum      <= 8'h00;
            load_pend   <= 1'b0;
            pos_snap    <= '0;
            din_snap    <= '0;
            rpm_snap    <= 16'h0000;
            status_snap <= 8'h00;
        end else begin
            rx_vld <= 1'b0;
            if (start_c) begin
                bitcnt      <= 3'd0;
                bytecnt     <= '0;
                rx_sum      <= 8'h00;
                load_pend   <= 1'b0;
                pos_snap    <= pos_in;
                din_snap    <= din;
                rpm_snap    <= rpm;
                status_snap <= {last_ok, err_cnt};
                // byte 0 is always the low byte of channel 0 position
                tx_sh       <= pos_in[7:0];
                tx_sum      <= pos_in[7:0];
            end else if (state == S_SHIFT) begin
                if (sck_rise_c) begin
                    rx_sh  <= {rx_sh[5:0], mosi_b};
                    bitcnt <= bitcnt + 3'd1;
                    if (byte_done_c) begin
                        rx_byte   <= rx_byte_c;
                        rx_idx    <= bytecnt;
                        rx_vld    <= 1'b1;
                        rx_sum    <= rx_sum + rx_byte_c;
                        bytecnt   <= bytecnt + BCW'(1);
                        load_pend <= 1'b1;
                    end
                end
                if (sck_fall_c) begin
                    if (load_pend) begin
                        tx_sh     <= tx_byte_c;
                        tx_sum    <= tx_sum + tx_byte_c;
                        load_pend <= 1'b0;
                    end else begin
                        tx_sh <= {tx_sh[6:0], 1'b0};
                    end
                end
            end else if (state != S_IDLE && sck_fall_c) begin
                tx_sh <= 8'h00;
            end
        end
    end

    assign spi.MISO = tx_sh[7];

    // Shadow registers, written the clk after each completed MOSI byte
    always_ff @(posedge clk) begin
        if (rst) begin
            vel_sh      <= '0;
            dout_sh     <= '0;
            spol_sh     <= 1'b0;
            wdt_en_sh   <= 1'b0;
            dirtime_sh  <= '0;
            steptime_sh <= '0;
            tap_sh      <= 2'b00;
            pwm_sh      <= 8'h00;
        end else if (rx_vld) begin
            for (int c = 0; c < CH; c++) begin
                if (rx_idx == BCW'(4*c))     vel_sh[c*VW +: 8]        <= rx_byte;
                if (rx_idx == BCW'(4*c + 1)) vel_sh[c*VW + 8 +: VW-8] <= rx_byte[VW-9:0];
            end
            if (rx_idx == BCW'(4*CH))     dout_sh[7:0]    <= rx_byte;
            if (rx_idx == BCW'(4*CH + 1)) dout_sh[OW-1:8] <= rx_byte[OW-9:0];
            if (rx_idx == BCW'(4*CH + 2)) begin
                spol_sh    <= rx_byte[7];
                wdt_en_sh  <= rx_byte[6];
                dirtime_sh <= rx_byte[T-1:0];
            end
            if (rx_idx == BCW'(4*CH + 3)) begin
                tap_sh      <= rx_byte[7:6];
                steptime_sh <= rx_byte[T-1:0];
            end
            if (rx_idx == BCW'(4*CH + 4)) pwm_sh <= rx_byte;
        end
    end

    // Commit on good checksum, count rejects otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            vel_out   <= '0;
            dout      <= '0;
            spolarity <= 1'b0;
            dirtime   <= '0;
            steptime  <= '0;
            tap       <= 2'b00;
            pwm       <= 8'h00;
            commit    <= 1'b0;
            wdt_kick  <= 1'b0;
            err_cnt   <= 7'd0;
            last_ok   <= 1'b0;
        end else begin
            commit   <= 1'b0;
            wdt_kick <= 1'b0;
            if (accept_c) begin
                vel_out   <= vel_sh;
                dout      <= dout_sh;
                spolarity <= spol_sh;
                dirtime   <= dirtime_sh;
                steptime  <= steptime_sh;
                tap       <= tap_sh;
                pwm       <= pwm_sh;
                commit    <= 1'b1;
                wdt_kick  <= wdt_en_sh;
                last_ok   <= 1'b1;
            end else if (reject_c) begin
                last_ok <= 1'b0;
                if (err_cnt != 7'd127) err_cnt <= err_cnt + 7'd1;
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: table of frames plus hand-written
// abort, snapshot, saturation and reset sequences.
module tb_spi_frame_slave;
    localparam int CH = 4, VW = 12, PW = 21, OW = 9, IW = 13, T = 4;
    localparam int N  = 4 * CH + 8;
    localparam int HP = 5;  // SCK half period in clk cycles

    typedef struct {
        logic [CH*VW-1:0] vel;
        logic [OW-1:0]    dout;
        logic [7:0]       ctrl;
        logic [7:0]       ts;
        logic [7:0]       pwm;
        logic [7:0]       cdelta;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [CH*PW-1:0] pos_in;
    logic [IW-1:0]    din;
    logic [15:0]      rpm;
    logic [CH*VW-1:0] vel_out;
    logic [OW-1:0]    dout;
    logic             spolarity, commit, wdt_kick;
    logic [T-1:0]     dirtime, steptime;
    logic [1:0]       tap;
    logic [7:0]       pwm;
    logic [6:0]       err_cnt;

    spi_frame_slave_if spi();

    spi_frame_slave #(.CH(CH), .VW(VW), .PW(PW), .OW(OW), .IW(IW), .T(T)) dut (
        .clk(clk), .rst(rst), .spi(spi), .pos_in(pos_in), .din(din), .rpm(rpm),
        .vel_out(vel_out), .dout(dout), .spolarity(spolarity), .dirtime(dirtime),
        .steptime(steptime), .tap(tap), .pwm(pwm), .commit(commit),
        .wdt_kick(wdt_kick), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor
    int n_commit = 0, n_kick = 0, kick_alone = 0, commit_long = 0, last_commit_cyc = 0;
    logic commit_d = 1'b0;
    always @(negedge clk) begin
        if (commit) begin
            n_commit++;
            last_commit_cyc = cyc;
            if (commit_d) commit_long++;
        end
        if (wdt_kick) begin
            n_kick++;
            if (!commit) kick_alone++;
        end
        commit_d = commit;
    end

    int n_vec = 0, n_bad = 0;
    int last_rise_cyc = 0;
    logic [7:0] mosi_buf [N+1];
    logic [7:0] miso_buf [N+1];
    logic [7:0] exp_miso [N+1];

    // Reference model of live state
    logic [CH*VW-1:0] e_vel = '0;
    logic [OW-1:0]    e_dout = '0;
    logic             e_spol = 1'b0, e_ok = 1'b0;
    logic [T-1:0]     e_dir = '0, e_step = '0;
    logic [1:0]       e_tap = '0;
    logic [7:0]       e_pwm = '0;
    int               e_err = 0, e_commit = 0, e_kick = 0;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi.MOSI = tx[i];
            repeat (HP) @(posedge clk);
            #1;
            spi.SCK = 1'b1;
            rx[i] = spi.MISO;
            last_rise_cyc = cyc;
            repeat (HP) @(posedge clk);
            #1;
            spi.SCK = 1'b0;
        end
    endtask

    task automatic run_frame(input int nb, input int chg_at, input bit raise);
        logic [7:0] r;
        spi.SSEL = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int k = 0; k < nb; k++) begin
            if (k == chg_at) pos_in[PW-1:0] = 21'h000200;
            spi_byte(mosi_buf[k], r);
            miso_buf[k] = r;
        end
        repeat (8) @(posedge clk);
        #1;
        if (raise) spi.SSEL = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic build(input vec_t v);
        logic [7:0] s;
        logic [VW-1:0] vv;
        for (int c = 0; c < CH; c++) begin
            vv = v.vel[c*VW +: VW];
            mosi_buf[4*c]     = vv[7:0];
            mosi_buf[4*c + 1] = 8'(vv[VW-1:8]);
            mosi_buf[4*c + 2] = 8'h5A ^ 8'(c);
            mosi_buf[4*c + 3] = 8'hC3;
        end
        mosi_buf[4*CH]     = v.dout[7:0];
        mosi_buf[4*CH + 1] = 8'(v.dout[OW-1:8]);
        mosi_buf[4*CH + 2] = v.ctrl;
        mosi_buf[4*CH + 3] = v.ts;
        mosi_buf[4*CH + 4] = v.pwm;
        mosi_buf[4*CH + 5] = 8'h11;
        mosi_buf[4*CH + 6] = 8'h22;
        mosi_buf[4*CH + 7] = 8'h33;
        s = 8'h00;
        for (int k = 0; k < N; k++) s = s + mosi_buf[k];
        mosi_buf[N] = 8'h00 - s + v.cdelta;
    endtask

    task automatic calc_miso(input logic [CH*PW-1:0] p, input logic [IW-1:0] d,
                             input logic [15:0] r, input logic [7:0] st);
        logic [31:0] w;
        logic [7:0]  s;
        for (int k = 0; k < 4 * CH; k++) begin
            w = 32'(p[(k/4)*PW +: PW]);
            exp_miso[k] = w[(k%4)*8 +: 8];
        end
        exp_miso[4*CH]     = d[7:0];
        exp_miso[4*CH + 1] = 8'(d[IW-1:8]);
        exp_miso[4*CH + 2] = r[7:0];
        exp_miso[4*CH + 3] = r[15:8];
        exp_miso[4*CH + 4] = st;
        exp_miso[4*CH + 5] = 8'hA5;
        exp_miso[4*CH + 6] = 8'h04;
        exp_miso[4*CH + 7] = 8'h00;
        s = 8'h00;
        for (int k = 0; k < N; k++) s = s + exp_miso[k];
        exp_miso[N] = 8'h00 - s;
    endtask

    task automatic check_miso(input string tag, input int nb);
        for (int k = 0; k < nb; k++)
            chk($sformatf("%s_miso_b%0d", tag, k), 64'(miso_buf[k]), 64'(exp_miso[k]));
    endtask

    task automatic model_frame(input vec_t v, input bit ok);
        if (ok) begin
            e_vel = v.vel; e_dout = v.dout; e_spol = v.ctrl[7]; e_dir = v.ctrl[T-1:0];
            e_tap = v.ts[7:6]; e_step = v.ts[T-1:0]; e_pwm = v.pwm; e_ok = 1'b1;
            e_commit++;
            if (v.ctrl[6]) e_kick++;
        end else begin
            e_ok = 1'b0;
            if (e_err < 127) e_err++;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_vel"},      64'(vel_out),   64'(e_vel));
        chk({tag, "_dout"},     64'(dout),      64'(e_dout));
        chk({tag, "_spol"},     64'(spolarity), 64'(e_spol));
        chk({tag, "_dirtime"},  64'(dirtime),   64'(e_dir));
        chk({tag, "_steptime"}, 64'(steptime),  64'(e_step));
        chk({tag, "_tap"},      64'(tap),       64'(e_tap));
        chk({tag, "_pwm"},      64'(pwm),       64'(e_pwm));
        chk({tag, "_err_cnt"},  64'(err_cnt),   64'(e_err));
        chk({tag, "_commits"},  64'(n_commit),  64'(e_commit));
        chk({tag, "_kicks"},    64'(n_kick),    64'(e_kick));
    endtask

    // Full frame from the table entry, with MISO and output checks
    task automatic do_vec(input string tag, input vec_t v, input int chg_at);
        bit ok;
        ok = (v.cdelta == 8'h00);
        calc_miso(pos_in, din, rpm, {e_ok, 7'(e_err)});
        build(v);
        run_frame(N + 1, chg_at, 1'b1);
        check_miso(tag, N + 1);
        model_frame(v, ok);
        check_outputs(tag);
        if (ok) chk({tag, "_commit_latency"}, 64'(last_commit_cyc - last_rise_cyc), 64'd4);
    endtask

    initial begin
        logic [7:0] r, acc;
        spi.SCK = 1'b0; spi.MOSI = 1'b0; spi.SSEL = 1'b1;
        pos_in = {21'h1FFFFF, 21'h0F00F0, 21'h1ABCDE, 21'h000100};
        din    = 13'h1A5C;
        rpm    = 16'hBEEF;

        vecs[0] = '{{12'h004, 12'h003, 12'h002, 12'h001}, 9'h0FF, 8'h83, 8'h42, 8'h11, 8'h00};
        vecs[1] = '{{12'h0FF, 12'h000, 12'h000, 12'h123}, 9'h1AB, 8'hC3, 8'hC5, 8'h80, 8'h00};
        vecs[2] = '{{12'h0FF, 12'h000, 12'h000, 12'h123}, 9'h1AB, 8'hC3, 8'hC5, 8'h80, 8'h01};
        vecs[3] = '{{12'h7E7, 12'h800, 12'hFFF, 12'h000}, 9'h000, 8'h4F, 8'h0A, 8'hFF, 8'h00};
        vecs[4] = '{{12'h111, 12'h222, 12'h333, 12'h444}, 9'h155, 8'hC1, 8'h81, 8'h33, 8'h80};

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset_commit", 64'(commit), 64'd0);
        chk("reset_miso", 64'(spi.MISO), 64'd0);

        // Table of full frames
        for (int i = 0; i < 5; i++) begin
            din = 13'h1A5C ^ 13'(i * 37);
            rpm = 16'hBEEF + 16'(i);
            do_vec($sformatf("vec%0d", i), vecs[i], -1);
        end

        // Select pulse with no bytes: nothing changes
        spi.SSEL = 1'b0;
        repeat (12) @(posedge clk);
        #1 spi.SSEL = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_outputs("empty_sel");

        // Deselect after 10 bytes, then a good frame still commits
        calc_miso(pos_in, din, rpm, {e_ok, 7'(e_err)});
        build(vecs[1]);
        run_frame(10, -1, 1'b1);
        check_miso("abort", 10);
        model_frame(vecs[1], 1'b0);
        check_outputs("abort");
        do_vec("after_abort", vecs[1], -1);

        // Channel 0 position changes during the frame; MISO keeps the snapshot
        do_vec("snap", vecs[0], 1);
        pos_in[PW-1:0] = 21'h000100;

        // Saturate the error counter with one-byte aborted frames
        for (int i = 0; i < 130; i++) begin
            mosi_buf[0] = 8'(i);
            run_frame(1, -1, 1'b1);
            model_frame(vecs[0], 1'b0);
        end
        check_outputs("saturate");
        chk("saturate_err_cnt", 64'(err_cnt), 64'd127);

        // Reset in the middle of a frame with select held low
        spi.SSEL = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) spi_byte(8'h5A, r);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e_vel = '0; e_dout = '0; e_spol = 1'b0; e_dir = '0; e_step = '0;
        e_tap = '0; e_pwm = '0; e_err = 0; e_ok = 1'b0;
        check_outputs("rst_mid");
        chk("rst_mid_miso", 64'(spi.MISO), 64'd0);
        build(vecs[1]);
        acc = 8'h00;
        for (int k = 0; k <= N; k++) begin
            spi_byte(mosi_buf[k], r);
            acc = acc | r;
        end
        repeat (10) @(posedge clk);
        #1;
        check_outputs("rst_held_low");
        chk("rst_held_low_miso", 64'(acc), 64'd0);
        spi.SSEL = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        do_vec("rst_recover", vecs[1], -1);

        chk("kick_without_commit", 64'(kick_alone), 64'd0);
        chk("commit_width", 64'(commit_long), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_frame_slave.md
Name: spi_frame_slave

Overview:
Parametrised SPI slave register frame for the stepper/IO CPLD. It carries CH stepgen channels plus digital IO, PWM and RPM in one fixed-layout frame. MOSI data goes into shadow registers and reaches the live outputs only when the frame ends with a valid checksum. MISO data is a coherent snapshot taken at frame start. It sits between the Raspberry Pi SPI pins and the stepgen, pwm/rcservo, wdt and rpm blocks.

Parameters:
CH, 4, number of stepgen channels (1..6)
VW, 12, velocity word width (9..16)
PW, 21, position width (9..32), zero-extended to 32 bits on MISO
OW, 9, digital output count (9..16)
IW, 13, digital input count (9..16)
T, 4, dirtime/steptime width (1..6)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
SCK  in  1  SPI clock, mode 0, asynchronous
MOSI  in  1  SPI data in, MSB first
MISO  out  1  SPI data out, MSB first
SSEL  in  1  SPI select, active low
pos_in  in  CH*PW  packed channel positions, channel 0 in LSBs
din  in  IW  digital inputs
rpm  in  16  spindle rpm count
vel_out  out  CH*VW  packed live velocities
dout  out  OW  live digital outputs
spolarity  out  1  step polarity
dirtime  out  T  dir setup time
steptime  out  T  step pulse time
tap  out  2  stepgen tap select
pwm  out  8  pwm/servo value
commit  out  1  one-cycle pulse when a valid frame is applied
wdt_kick  out  1  one-cycle pulse, coincident with commit, when ctrl bit 6 = 1
err_cnt  out  7  saturating count of rejected frames

Behaviour:
- SCK, SSEL and MOSI each pass through a 3-flop synchroniser. Edges are detected on stages [2:1]. Minimum SCK half-period is 4 clk.
- FSM states:
  - IDLE: wait for SSEL falling edge.
  - SHIFT: on start, clear bitcnt/bytecnt and snapshot pos_in, din, rpm.
  - CHECK: entered on the 8th rising edge of the byte at index N = 4*CH+8. Compares the checksum, goes to DONE the next cycle.
  - DONE: ignore further bytes and send MISO 0x00 until SSEL rises, then go to IDLE.
- Frame byte k (MOSI / MISO):
  - k = 4c+b, c<CH: MOSI b0 = vel[7:0], b1 = vel[VW-1:8], b2/b3 reserved. MISO = snapshot pos_c byte b.
  - 4CH+0: MOSI dout[7:0]; MISO din[7:0].
  - 4CH+1: MOSI dout[OW-1:8]; MISO din[IW-1:8], zero-extended.
  - 4CH+2: MOSI ctrl = {spol, wdt_en, 0.., dirtime[T-1:0]}; MISO rpm[7:0].
  - 4CH+3: MOSI {tap[1:0], 0.., steptime[T-1:0]}; MISO rpm[15:8].
  - 4CH+4: MOSI pwm; MISO status = {last_frame_ok, err_cnt}.
  - 4CH+5: MOSI reserved; MISO 0xA5.
  - 4CH+6: MOSI reserved; MISO CH.
  - 4CH+7: MOSI reserved; MISO 0x00.
  - N: MOSI checksum; MISO checksum.
- Checksum rule: the 8-bit sum mod 256 of all bytes 0..N must be 0x00. This applies to both directions. Reserved bytes are included in the sum.
- MISO timing: byte 0 is loaded at the SSEL start. Byte k is loaded on the SCK falling edge after the 8th rising edge of byte k-1. Shift on every SCK falling edge. MISO = shift reg bit 7.
- MOSI is sampled on SCK rising edges. Each completed byte is written into its shadow register the next clk.
- Valid checksum: one clk after CHECK, copy all shadows to live outputs and pulse commit. Pulse wdt_kick if shadow wdt_en = 1. Set last_frame_ok = 1.
- Reject cases, each with no output change, last_frame_ok = 0 and err_cnt +1 saturating at 127:
  - bad checksum;
  - SSEL rising before CHECK with bytecnt >= 1.
- SSEL pulse with zero bytes: no effect.
- SSEL falling while in DONE or SHIFT: starts a new frame. The previous incomplete frame counts as a reject.
- Reset values: vel_out 0, dout 0, spolarity 0, dirtime 0, steptime 0, tap 0, pwm 0, commit 0, wdt_kick 0, err_cnt 0, last_frame_ok 0, MISO 0, FSM IDLE.
- Reset mid-frame: abort with no commit and no error count. The FSM waits for SSEL high before accepting a new start.

Test Plan:
- CH=4, valid frame with vel0=0x123, vel3=0x0FF, dout=0x1AB, pwm=0x80 → commit high exactly 1 clk after checksum byte; vel_out/dout/pwm updated; MISO bytes 16..23 = din lo, din hi, rpm lo, rpm hi, 0x80, 0xA5, 0x04, 0x00.
- Same frame with checksum +1 → outputs unchanged, no commit; err_cnt = 1; next frame status byte = 0x01.
- SSEL raised after 10 bytes → no commit, err_cnt increments; following valid frame commits normally.
- pos_in[0] changes 0x000100 → 0x000200 mid-frame → MISO bytes 0..2 = 00 01 00; MISO checksum matches the snapshot.
- ctrl = 0xC3 in a valid frame → spolarity=1, dirtime=3, wdt_kick pulse coincident with commit; ctrl = 0x83 → no wdt_kick.
- 130 bad frames → err_cnt holds 127. rst asserted mid-frame → all outputs at reset values; SSEL still low → no capture until SSEL high then low.
